// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, branch flush, load-use stall and EX forwarding.
// Optional performance counters are built in when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rfRn,
  input  logic [4:0]  rfRm,
  input  logic        rfUsesRn,
  input  logic        rfUsesRm,
  input  logic [4:0]  exRn,
  input  logic [4:0]  exRm,
  input  logic [4:0]  exRd,
  input  logic        exRegWrite,
  input  logic        exLoad,
  input  logic        brTakenEX,
  input  logic [4:0]  memRd,
  input  logic        memRegWrite,
  input  logic        memReq,
  input  logic        memAck,
  input  logic [4:0]  wbRd,
  input  logic        wbRegWrite,
  output logic        pcWrEn,
  output logic        ifrfWrEn,
  output logic        rfexWrEn,
  output logic        exmemWrEn,
  output logic        memwbWrEn,
  output logic        ifrfFlush,
  output logic        rfexFlush,
  output logic [1:0]  fwdA,
  output logic [1:0]  fwdB,
  output logic        memErr,
  output logic [1:0]  state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stallCycles,
  output logic [31:0] flushCount
`endif
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned WAIT_W = 8;
  localparam logic [REG_W-1:0]  ZERO_REG   = REG_W'(31);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = '1;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    ERR     = 2'b10
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [WAIT_W-1:0]  wait_q;
  logic [WAIT_W-1:0]  wait_d;
  logic               err_d;
  logic               mem_stall;
  logic               load_use;

  assign state = state_q;

  // Newest producer wins: EX/MEM result is younger than MEM/WB.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic             mem_wr,
    input logic [REG_W-1:0] mem_rd,
    input logic             wb_wr,
    input logic [REG_W-1:0] wb_rd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_wr && (mem_rd == src) && (mem_rd != ZERO_REG)) begin
      sel = FWD_EXMEM;
    end else if (wb_wr && (wb_rd == src) && (wb_rd != ZERO_REG)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  // Load in EX whose destination is read by the instruction in RF.
  always_comb begin
    load_use = 1'b0;
    if (exLoad && exRegWrite && (exRd != ZERO_REG)) begin
      load_use = (rfUsesRn && (rfRn == exRd)) || (rfUsesRm && (rfRm == exRd));
    end
  end

  // Pipe is frozen while data memory has not acknowledged, and forever in ERR.
  always_comb begin
    mem_stall = 1'b1;
    unique case (state_q)
      RUN:     mem_stall = memReq && !memAck;
      MEMWAIT: mem_stall = !memAck;
      ERR:     mem_stall = 1'b1;
      default: mem_stall = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      memErr  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      memErr  <= err_d;
    end
  end

  // The RUN cycle that first sees the unacknowledged request counts as wait cycle one.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = memErr;
    unique case (state_q)
      RUN: begin
        wait_d = '0;
        if (memReq && !memAck) begin
          state_d = MEMWAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEMWAIT: begin
        if (memAck) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_q == (WAIT_LIMIT - WAIT_W'(1))) begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      ERR: begin
        state_d = ERR;
        err_d   = 1'b1;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Stage control: freeze > branch flush > load-use stall; reset forces a free-running pipe.
  always_comb begin
    pcWrEn    = 1'b1;
    ifrfWrEn  = 1'b1;
    rfexWrEn  = 1'b1;
    exmemWrEn = 1'b1;
    memwbWrEn = 1'b1;
    ifrfFlush = 1'b0;
    rfexFlush = 1'b0;
    fwdA      = FWD_RF;
    fwdB      = FWD_RF;
    if (reset) begin
      fwdA = fwd_sel(exRn, memRegWrite, memRd, wbRegWrite, wbRd);
      fwdB = fwd_sel(exRm, memRegWrite, memRd, wbRegWrite, wbRd);
      if (mem_stall) begin
        pcWrEn    = 1'b0;
        ifrfWrEn  = 1'b0;
        rfexWrEn  = 1'b0;
        exmemWrEn = 1'b0;
        memwbWrEn = 1'b0;
      end else if (brTakenEX) begin
        ifrfFlush = 1'b1;
        rfexFlush = 1'b1;
      end else if (load_use) begin
        pcWrEn    = 1'b0;
        ifrfWrEn  = 1'b0;
        rfexFlush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam int unsigned CNT_W = 32;

  logic stall_event;
  logic flush_event;

  assign stall_event = mem_stall || (!brTakenEX && load_use);
  assign flush_event = !mem_stall && brTakenEX;

  // Saturating event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      if (stall_event && (stallCycles != '1)) begin
        stallCycles <= stallCycles + CNT_W'(1);
      end
      if (flush_event && (flushCount != '1)) begin
        flushCount <= flushCount + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  rfRn, rfRm, exRn, exRm, exRd, memRd, wbRd;
  logic        rfUsesRn, rfUsesRm, exRegWrite, exLoad, brTakenEX;
  logic        memRegWrite, memReq, memAck, wbRegWrite;
  logic        pcWrEn, ifrfWrEn, rfexWrEn, exmemWrEn, memwbWrEn;
  logic        ifrfFlush, rfexFlush, memErr;
  logic [1:0]  fwdA, fwdB, state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCycles, flushCount;
`endif

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .rfRn(rfRn), .rfRm(rfRm), .rfUsesRn(rfUsesRn), .rfUsesRm(rfUsesRm),
    .exRn(exRn), .exRm(exRm), .exRd(exRd), .exRegWrite(exRegWrite), .exLoad(exLoad),
    .brTakenEX(brTakenEX),
    .memRd(memRd), .memRegWrite(memRegWrite), .memReq(memReq), .memAck(memAck),
    .wbRd(wbRd), .wbRegWrite(wbRegWrite),
    .pcWrEn(pcWrEn), .ifrfWrEn(ifrfWrEn), .rfexWrEn(rfexWrEn),
    .exmemWrEn(exmemWrEn), .memwbWrEn(memwbWrEn),
    .ifrfFlush(ifrfFlush), .rfexFlush(rfexFlush),
    .fwdA(fwdA), .fwdB(fwdB), .memErr(memErr), .state(state)
`ifdef HAZARD_PERF_CNT_EN
    , .stallCycles(stallCycles), .flushCount(flushCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;

  // Reference model: a mode, how long the current memory access has gone unacknowledged, sticky error.
  localparam int M_RUN = 0, M_WAIT = 1, M_ERR = 2;
  int          m_mode;
  int          m_unacked;
  bit          m_err;
  logic [31:0] m_stalls;
  logic [31:0] m_flushes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_mode = M_RUN; m_unacked = 0; m_err = 0; m_stalls = '0; m_flushes = '0;
  endtask

  function automatic logic [1:0] mode_code(input int mode);
    return (mode == M_WAIT) ? 2'b01 : (mode == M_ERR) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    logic [1:0] f;
    f = 2'b00;
    if (wbRegWrite && wbRd == src && wbRd != 5'd31) f = 2'b10;
    if (memRegWrite && memRd == src && memRd != 5'd31) f = 2'b01;
    return f;
  endfunction

  // Check every output against the rules for the current inputs, then clock once and advance the model.
  task automatic step();
    bit frozen, lu, br_applied, lu_applied;
    logic [6:0] ctl;
    if (!reset) model_clear();
    #1;
    frozen = (m_mode == M_ERR) || (!memAck && (m_mode == M_WAIT || memReq));
    lu = exLoad && exRegWrite && exRd != 5'd31 &&
         ((rfUsesRn && rfRn == exRd) || (rfUsesRm && rfRm == exRd));
    br_applied = reset && !frozen && brTakenEX;
    lu_applied = reset && !frozen && !brTakenEX && lu;
    // {pc, ifrf, rfex, exmem, memwb, ifrfFlush, rfexFlush}
    if (!reset)          ctl = 7'b11111_00;
    else if (frozen)     ctl = 7'b00000_00;
    else if (brTakenEX)  ctl = 7'b11111_11;
    else if (lu)         ctl = 7'b00111_01;
    else                 ctl = 7'b11111_00;
    chk("pcWrEn",    pcWrEn,    ctl[6]);
    chk("ifrfWrEn",  ifrfWrEn,  ctl[5]);
    chk("rfexWrEn",  rfexWrEn,  ctl[4]);
    chk("exmemWrEn", exmemWrEn, ctl[3]);
    chk("memwbWrEn", memwbWrEn, ctl[2]);
    chk("ifrfFlush", ifrfFlush, ctl[1]);
    chk("rfexFlush", rfexFlush, ctl[0]);
    chk("fwdA", fwdA, reset ? exp_fwd(exRn) : 2'b00);
    chk("fwdB", fwdB, reset ? exp_fwd(exRm) : 2'b00);
    chk("state", state, mode_code(m_mode));
    chk("memErr", memErr, m_err);
`ifdef HAZARD_PERF_CNT_EN
    chk("stallCycles", stallCycles, m_stalls);
    chk("flushCount", flushCount, m_flushes);
`endif
    @(posedge clk);
    if (reset) begin
      if (frozen || lu_applied) m_stalls = (m_stalls == '1) ? m_stalls : m_stalls + 1;
      if (br_applied)           m_flushes = (m_flushes == '1) ? m_flushes : m_flushes + 1;
      if (m_mode != M_ERR) begin
        if (memAck || (m_mode == M_RUN && !memReq)) begin
          m_mode = M_RUN; m_unacked = 0;
        end else begin
          m_unacked++;
          m_mode = (m_unacked >= 255) ? M_ERR : M_WAIT;
          if (m_unacked >= 255) m_err = 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rfRn = 0; rfRm = 0; rfUsesRn = 0; rfUsesRm = 0;
    exRn = 0; exRm = 0; exRd = 0; exRegWrite = 0; exLoad = 0; brTakenEX = 0;
    memRd = 0; memRegWrite = 0; memReq = 0; memAck = 0; wbRd = 0; wbRegWrite = 0;
  endtask

  // Register numbers from a small pool plus X31 so that matches are frequent.
  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
  endfunction

  task automatic random_inputs();
    rfRn = rreg(); rfRm = rreg(); rfUsesRn = 1'($urandom); rfUsesRm = 1'($urandom);
    exRn = rreg(); exRm = rreg(); exRd = rreg();
    exRegWrite = 1'($urandom); exLoad = 1'($urandom);
    brTakenEX = ($urandom_range(0, 5) == 0);
    memRd = rreg(); memRegWrite = 1'($urandom); wbRd = rreg(); wbRegWrite = 1'($urandom);
    memReq = ($urandom_range(0, 3) == 0);
    memAck = ($urandom_range(0, 2) != 0);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    model_clear();
    @(negedge clk);

    // Reset overrides every hazard source.
    repeat (3) begin random_inputs(); memReq = 1; memAck = 0; brTakenEX = 1; step(); end
    clear_inputs();
    reset = 1'b1;
    step();

    // Load-use: LDUR X1 in EX, ADD reads X1 in RF.
    exLoad = 1; exRegWrite = 1; exRd = 5'd1; rfRn = 5'd1; rfUsesRn = 1;
    #1;
    chk("lu_pcWrEn", pcWrEn, 1'b0);
    chk("lu_ifrfWrEn", ifrfWrEn, 1'b0);
    chk("lu_rfexFlush", rfexFlush, 1'b1);
    step();
    clear_inputs();
    #1;
    chk("lu_after_pcWrEn", pcWrEn, 1'b1);
    step();

    // Three unacknowledged cycles then ack.
    memReq = 1; memAck = 0;
    #1 chk("mw_freeze0", {pcWrEn, exmemWrEn}, 2'b00);
    repeat (3) step();
    chk("mw_state_ack", state, 2'b01);
    memAck = 1;
    #1 chk("mw_release", {pcWrEn, memwbWrEn}, 2'b11);
    step();
    chk("mw_state_run", state, 2'b00);
    clear_inputs();
    step();

    // Branch coincident with load-use: flush wins, no stall.
    brTakenEX = 1; exLoad = 1; exRegWrite = 1; exRd = 5'd2; rfRm = 5'd2; rfUsesRm = 1;
    #1 chk("br_lu", {pcWrEn, ifrfWrEn, ifrfFlush, rfexFlush}, 4'b1111);
    step();
    // Branch arriving during freeze applied on the release cycle.
    clear_inputs();
    memReq = 1; brTakenEX = 1;
    step();
    memAck = 1;
    #1 chk("br_release", {ifrfFlush, rfexFlush, pcWrEn}, 3'b111);
    step();

    // Forwarding priority and X31.
    clear_inputs();
    memRd = 5; wbRd = 5; memRegWrite = 1; wbRegWrite = 1; exRn = 5; exRm = 5;
    #1 chk("fwd_mem", fwdA, 2'b01);
    step();
    memRd = 31; exRn = 31; exRm = 5;
    #1 chk("fwd_x31", fwdA, 2'b00);
    chk("fwd_wb", fwdB, 2'b10);
    step();
    exLoad = 1; exRegWrite = 1; exRd = 31; rfRn = 31; rfUsesRn = 1;
    #1 chk("x31_no_stall", pcWrEn, 1'b1);
    step();

    // Randomized traffic with occasional asynchronous reset.
    for (int i = 0; i < 1500; i++) begin
      random_inputs();
      reset = ($urandom_range(0, 63) != 0);
      step();
    end
    reset = 1'b1;
    clear_inputs();
    step();

    // Memory timeout into ERR, then asynchronous reset recovery.
    memReq = 1; memAck = 0;
    repeat (254) step();
    chk("to_pre_state", state, 2'b01);
    chk("to_pre_err", memErr, 1'b0);
    step();
    chk("to_state", state, 2'b10);
    chk("to_err", memErr, 1'b1);
    memReq = 0; brTakenEX = 1;
    step();
    #2 reset = 1'b0;
    #1;
    chk("async_state", state, 2'b00);
    chk("async_err", memErr, 1'b0);
    chk("async_pc", pcWrEn, 1'b1);
    model_clear();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-003 SHALL have: rfRn, rfRm  in  5 each  source registers of instruction in RF; rfUsesRn, rfUsesRm  in  1 each  operand actually read.
REQ-004 SHALL have: exRn, exRm  in  5 each  sources of instruction in EX; exRd  in  5; exRegWrite, exLoad  in  1 each; brTakenEX  in  1  branch resolved taken in EX.
REQ-005 SHALL have: memRd  in  5; memRegWrite  in  1; memReq  in  1  MEM-stage access active; memAck  in  1  data memory done.
REQ-006 SHALL have: wbRd  in  5; wbRegWrite  in  1.
REQ-007 SHALL have: pcWrEn, ifrfWrEn, rfexWrEn, exmemWrEn, memwbWrEn  out  1 each  stage-register enables.
REQ-008 SHALL have: ifrfFlush, rfexFlush  out  1 each  load NOP into that register; fwdA, fwdB  out  2 each  EX operand select (00 regfile, 01 EX/MEM, 10 MEM/WB); memErr  out  1  sticky timeout; state  out  2.

Function
REQ-009 SHALL implement states RUN=00, MEMWAIT=01, ERR=10.
REQ-010 In RUN, memReq=1 and memAck=0 SHALL freeze the pipe that cycle (all five WrEn=0, flushes=0) and enter MEMWAIT next edge.
REQ-011 In MEMWAIT, freeze SHALL persist while memAck=0; memAck=1 SHALL release freeze that same cycle and return to RUN.
REQ-012 memReq=1 with memAck=1 in the same RUN cycle SHALL cause no freeze.
REQ-013 An 8-bit wait counter SHALL count MEMWAIT cycles; reaching 255 SHALL set memErr=1 and enter ERR; ERR holds freeze until reset.
REQ-014 Load-use (exLoad=1, exRegWrite=1, exRd!=31, exRd matching rfRn with rfUsesRn, or rfRm with rfUsesRm) in RUN SHALL assert pcWrEn=0, ifrfWrEn=0, rfexFlush=1, other enables 1, for that cycle only.
REQ-015 brTakenEX=1 in RUN with no freeze SHALL assert ifrfFlush=1, rfexFlush=1, all enables 1.
REQ-016 Priority SHALL be freeze > branch flush > load-use stall; branch arriving during freeze SHALL be applied on release cycle.
REQ-017 fwdA SHALL be 01 if memRegWrite and memRd==exRn and memRd!=31; else 10 if wbRegWrite and wbRd==exRn and wbRd!=31; else 00; fwdB identical using exRm.
REQ-018 Register X31 SHALL never trigger stall or forwarding.

Reset
REQ-019 During/after reset: state=RUN, wait counter=0, memErr=0, counters=0.
REQ-020 While reset=0, outputs SHALL be: all WrEn=1, flushes=0, fwdA=fwdB=00.
REQ-021 Reset assertion mid-MEMWAIT or in ERR SHALL return to RUN without waiting for an edge.

Configuration
REQ-022 Macro HAZARD_PERF_CNT_EN SHALL gate performance counters.
REQ-023 Defined: outputs stallCycles  out  32 (increments each freeze or load-use cycle) and flushCount  out  32 (increments each applied branch flush), saturating at all-ones, not counting during reset.
REQ-024 Undefined: both ports and counters absent; all other behaviour identical.

Verification
REQ-025 LDUR X1 in EX, ADD reading X1 in RF -> one cycle pcWrEn=0, ifrfWrEn=0, rfexFlush=1; next cycle all enables 1.
REQ-026 memReq=1, memAck=0 for 3 cycles then 1 -> state=01 for 3 cycles, freeze 3 cycles, released on ack cycle; stallCycles=3 with macro.
REQ-027 brTakenEX=1 coincident with load-use -> ifrfFlush=rfexFlush=1, pcWrEn=1, no stall; flushCount=1.
REQ-028 memRd=wbRd=5, both writing, exRn=5 -> fwdA=01; memRd=31 -> fwdA=10; exRd=31 load -> no stall.
REQ-029 memAck held 0 for 255 cycles -> memErr=1, state=10; reset pulse low -> state=00, memErr=0 asynchronously.
